// File: rtl/scan_pkg.sv
// Shared types and advance rule for the scan select generator.
package scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STEP_WAIT,
    STEP_ACK
  } state_t;

  localparam int IDX_W = 3;
  localparam logic [IDX_W-1:0] MAX_IDX = 3'd7;
  localparam int BLANK_CYCLES = 2;

  // Returns {wrap, new_idx}; an index already past last_idx is treated as a wrap point.
  function automatic logic [IDX_W:0] next_idx(input logic [IDX_W-1:0] idx,
                                               input logic [IDX_W-1:0] last_idx,
                                               input logic             dir);
    logic [IDX_W:0] res;
    if (!dir) begin
      res = (idx >= last_idx) ? {1'b1, {IDX_W{1'b0}}} : {1'b0, idx + 1'b1};
    end else begin
      res = ((idx == '0) || (idx > last_idx)) ? {1'b1, last_idx} : {1'b0, idx - 1'b1};
    end
    return res;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running divider: tick is high on the last count of each PRESCALE-cycle period.
module scan_prescaler #(
  parameter int PRESCALE = 1000,
  parameter int CNT_W    = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] TERM = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt;

  // Counter stays at zero while cleared, so tick can only fire after a full period of counting.
  assign tick = (cnt == TERM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || (cnt == TERM)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scan_select_gen.sv
// Registered 3-bit select sequencer for the 3-to-8 decoder: free-run scan or req/ack single-step.
// Optional SCAN_BLANK_EN adds a blank output covering IDLE and a short gap after every advance.
module scan_select_gen
  import scan_pkg::*;
#(
  parameter int PRESCALE = 1000,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic                 dir,
  input  logic [IDX_W-1:0]     last_idx,
  input  logic                 step_req,
  output logic                 step_ack,
  output logic                 A,
  output logic                 B,
  output logic                 C,
  output logic                 sel_valid,
`ifdef SCAN_BLANK_EN
  output logic                 blank,
`endif
  output logic                 wrap
);

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   adv_res;
  logic             adv;
  logic             pre_clr;
  logic             tick;

  scan_prescaler #(
    .PRESCALE (PRESCALE),
    .CNT_W    (CNT_W)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pre_clr),
    .tick  (tick)
  );

  // Mode is only honoured in RUN/STEP_WAIT; STEP_ACK must finish its handshake first.
  always_comb begin
    state_nxt = state;
    adv       = 1'b0;
    pre_clr   = 1'b1;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      state_nxt = mode ? STEP_WAIT : RUN;
        RUN: begin
          if (mode) begin
            state_nxt = STEP_WAIT;
          end else begin
            pre_clr = 1'b0;
            adv     = tick;
          end
        end
        STEP_WAIT: begin
          if (!mode) begin
            state_nxt = RUN;
          end else if (step_req) begin
            adv       = 1'b1;
            state_nxt = STEP_ACK;
          end
        end
        STEP_ACK:  if (!step_req) state_nxt = STEP_WAIT;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  assign adv_res = next_idx(idx, last_idx, dir);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      wrap  <= adv & adv_res[IDX_W];
      if (adv) idx <= adv_res[IDX_W-1:0];
    end
  end

  assign {A, B, C} = idx;
  assign step_ack  = (state == STEP_ACK);

`ifdef SCAN_BLANK_EN
  logic [1:0] blank_cnt;

  // blank_cnt holds the remaining gap cycles after the first one signalled by adv itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blank     <= 1'b1;
      blank_cnt <= '0;
    end else begin
      blank <= adv || (blank_cnt != '0) || (state_nxt == IDLE);
      if (adv) begin
        blank_cnt <= 2'(BLANK_CYCLES - 1);
      end else if (blank_cnt != '0) begin
        blank_cnt <= blank_cnt - 1'b1;
      end
    end
  end

  assign sel_valid = (state != IDLE) && !blank;
`else
  assign sel_valid = (state != IDLE);
`endif

endmodule
